d_mem_arbiter: RTL and testbench
================================

# d_mem_arbiter

Two-port arbiter and access sequencer in front of the data memory `d_mem`. It lets the CPU load/store unit (port 0) and the debug/DMA loader (port 1) share the single memory port. Each access runs as a three-state transaction with round-robin fairness. Out-of-range addresses are range-checked and answered with an error response; they never reach the memory.

## Interface
Parameters:
- `DATA_WIDTH`, 32: data word width.
- `ADDR_WIDTH`, 32: requester address width (word index).
- `RAM_SIZE`, 256: number of memory words. An address is valid when `Addr < RAM_SIZE`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `Req0`, `Req1`  in  1  access request; held high until the matching `Ack`.
- `We0`, `We1`  in  1  1 = write, 0 = read; held stable with `Req`.
- `Addr0`, `Addr1`  in  ADDR_WIDTH  word address; held stable with `Req`.
- `WData0`, `WData1`  in  DATA_WIDTH  write data; held stable with `Req`.
- `Ack0`, `Ack1`  out  1  one-cycle completion pulse.
- `Err0`, `Err1`  out  1  valid with `Ack`; 1 = address out of range.
- `RData0`, `RData1`  out  DATA_WIDTH  read data, valid with `Ack`; holds its value until the next `Ack` on that port.
- `MemAddress`  out  ADDR_WIDTH  to d_mem `Address`.
- `MemWriteData`  out  DATA_WIDTH  to d_mem `WriteData`.
- `MemWrite`, `MemRead`  out  1  d_mem strobes.
- `MemReadData`  in  DATA_WIDTH  from d_mem `ReadData`.

## Operation
- FSM states: `IDLE`, `ACCESS`, `DONE`.
- `IDLE`:
  - With no request, remain in `IDLE`.
  - With one request, grant it.
  - With both requesting, grant the port that is not `LastGrant`.
  - On grant, latch the port index, `We`, `Addr` and `WData`, update `LastGrant`, then go to `ACCESS`.
- `ACCESS`:
  - Registered outputs drive `MemAddress` and `MemWriteData` from the latch.
  - `MemWrite = We` and `MemRead = !We`, only when `Addr < RAM_SIZE`; otherwise both strobes stay 0.
  - Always go to `DONE`.
- `DONE`:
  - Pulse `Ack` of the granted port for one cycle.
  - For a valid read, `RData` of that port takes the `MemReadData` sampled at the end of `ACCESS`.
  - For an out-of-range access, set `Err=1` and `RData=0`.
  - For a valid write, leave `RData` unchanged and keep `Err=0`.
  - Always return to `IDLE`.
- Requests are not sampled in `ACCESS` or `DONE`. A `Req` still high in the cycle after `Ack` is treated as a new request.
- Strobes are never asserted outside `ACCESS`. `MemRead` and `MemWrite` are never both high.
- Address comparison is unsigned, at full `ADDR_WIDTH`, with no truncation.
- Reset values:
  - State `IDLE`.
  - `LastGrant=1`, so port 0 wins the first contention.
  - All `Ack`, `Err`, `RData`, `Mem*` outputs 0.
- Reset asserted mid-transaction aborts it: no `Ack` is issued. If `rst_n` falls during `ACCESS`, the strobes drop immediately (asynchronous).

## Timing
- Cycle N: `Req` high in `IDLE`, sampled at the edge ending cycle N.
- Cycle N+1: `ACCESS`, strobes high.
- Cycle N+2: `Ack`, `Err` and `RData` valid.
- Latency is 2 cycles from the sampling edge to `Ack`. Throughput is one access per 3 cycles.
- The earliest re-grant is at the edge ending N+3; a loser waits at most one transaction.
- All outputs are registered, with no combinational path from `Req` to any output.

## Structure
- Shared package `mips_pkg`:
  - `arb_state_t` enum (`IDLE`, `ACCESS`, `DONE`).
  - Port index constants `PORT_CPU=0` and `PORT_DBG=1`.
- Sub-module `rr_arb2`: combinational 2-way round-robin pick. Inputs are `Req0`, `Req1` and `LastGrant`; outputs are `GrantValid` and `GrantIdx`.
- The FSM, request latch, range check and response registers are in the top module.

## Test plan
- Reset: with `rst_n` low, all outputs are 0. After release with no `Req`, the memory strobes stay 0 for 10 cycles.
- Single write then read on port 0:
  - Write `Addr0=5`, `WData0=0xDEADBEEF`: `MemWrite` high for exactly 1 cycle, then `Ack0` with `Err0=0`.
  - Read of address 5: `Ack0` with `RData0=0xDEADBEEF`, 2 cycles after sampling.
- Contention: `Req0` and `Req1` rise in the same cycle and both stay high.
  - Grant order is 0, 1, 0, 1.
  - `Ack` pulses land 3 cycles apart.
  - `Ack0` and `Ack1` are never high together.
- Out-of-range access on port 1 at `Addr1=256` (`RAM_SIZE=256`):
  - No strobe is asserted.
  - `Ack1` arrives with `Err1=1` and `RData1=0`.
  - Memory at index 0 is unchanged.
- Reset during `ACCESS`: drive `rst_n` low.
  - Strobes drop in the same cycle and no `Ack` follows.
  - After release with `Req1` held, port 1 is granted normally.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the data-memory arbiter.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/d_mem_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, contention goes to the port
// that did not win last time.
module rr_arb2
  import mips_pkg::*;
(
  input  logic Req0,
  input  logic Req1,
  input  logic LastGrant,
  output logic GrantValid,
  output logic GrantIdx
);

  always_comb begin
    GrantValid = Req0 | Req1;
    if (Req0 && Req1) begin
      GrantIdx = ~LastGrant;
    end else if (Req1) begin
      GrantIdx = PORT_DBG;
    end else begin
      GrantIdx = PORT_CPU;
    end
  end

endmodule

// File: rtl/d_mem_arbiter.sv
// Shares the single d_mem port between the load/store unit (port 0) and the
// debug/DMA loader (port 1); each access is IDLE -> ACCESS -> DONE.
module d_mem_arbiter
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int RAM_SIZE   = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Req0,
  input  logic                  Req1,
  input  logic                  We0,
  input  logic                  We1,
  input  logic [ADDR_WIDTH-1:0] Addr0,
  input  logic [ADDR_WIDTH-1:0] Addr1,
  input  logic [DATA_WIDTH-1:0] WData0,
  input  logic [DATA_WIDTH-1:0] WData1,
  output logic                  Ack0,
  output logic                  Ack1,
  output logic                  Err0,
  output logic                  Err1,
  output logic [DATA_WIDTH-1:0] RData0,
  output logic [DATA_WIDTH-1:0] RData1,
  output logic [ADDR_WIDTH-1:0] MemAddress,
  output logic [DATA_WIDTH-1:0] MemWriteData,
  output logic                  MemWrite,
  output logic                  MemRead,
  input  logic [DATA_WIDTH-1:0] MemReadData
);

  // One extra bit so RAM_SIZE itself is representable even when it equals 2**ADDR_WIDTH.
  localparam logic [ADDR_WIDTH:0] RAM_LIMIT = (ADDR_WIDTH + 1)'(RAM_SIZE);

  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
    return {1'b0, addr} < RAM_LIMIT;
  endfunction

  arb_state_t            state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  gnt_idx_q, gnt_idx_d;
  logic                  we_q, we_d;
  logic                  ok_q, ok_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  mem_write_q, mem_write_d;
  logic                  mem_read_q, mem_read_d;
  logic                  ack0_q, ack0_d;
  logic                  ack1_q, ack1_d;
  logic                  err0_q, err0_d;
  logic                  err1_q, err1_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

  logic                  grant_valid;
  logic                  grant_idx;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  sel_ok;

  rr_arb2 u_rr_arb2 (
    .Req0       (Req0),
    .Req1       (Req1),
    .LastGrant  (last_grant_q),
    .GrantValid (grant_valid),
    .GrantIdx   (grant_idx)
  );

  always_comb begin
    sel_we    = (grant_idx == PORT_DBG) ? We1    : We0;
    sel_addr  = (grant_idx == PORT_DBG) ? Addr1  : Addr0;
    sel_wdata = (grant_idx == PORT_DBG) ? WData1 : WData0;
    sel_ok    = addr_in_range(sel_addr);
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_idx_d    = gnt_idx_q;
    we_d         = we_q;
    ok_d         = ok_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_write_d  = 1'b0;
    mem_read_d   = 1'b0;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    err0_d       = 1'b0;
    err1_d       = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;

    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          gnt_idx_d    = grant_idx;
          last_grant_d = grant_idx;
          we_d         = sel_we;
          ok_d         = sel_ok;
          mem_addr_d   = sel_addr;
          mem_wdata_d  = sel_wdata;
          // Strobes are registered here so they are high exactly during ACCESS.
          mem_write_d  = sel_we & sel_ok;
          mem_read_d   = ~sel_we & sel_ok;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        // MemReadData is captured on the edge that closes ACCESS.
        if (gnt_idx_q == PORT_CPU) begin
          ack0_d = 1'b1;
          err0_d = ~ok_q;
          if (!ok_q) begin
            rdata0_d = '0;
          end else if (!we_q) begin
            rdata0_d = MemReadData;
          end
        end else begin
          ack1_d = 1'b1;
          err1_d = ~ok_q;
          if (!ok_q) begin
            rdata1_d = '0;
          end else if (!we_q) begin
            rdata1_d = MemReadData;
          end
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= PORT_DBG;
      gnt_idx_q    <= PORT_CPU;
      we_q         <= 1'b0;
      ok_q         <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_idx_q    <= gnt_idx_d;
      we_q         <= we_d;
      ok_q         <= ok_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_write_q  <= mem_write_d;
      mem_read_q   <= mem_read_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign Ack0         = ack0_q;
  assign Ack1         = ack1_q;
  assign Err0         = err0_q;
  assign Err1         = err1_q;
  assign RData0       = rdata0_q;
  assign RData1       = rdata1_q;
  assign MemAddress   = mem_addr_q;
  assign MemWriteData = mem_wdata_q;
  assign MemWrite     = mem_write_q;
  assign MemRead      = mem_read_q;

endmodule

// File: tb/tb_d_mem_arbiter.sv
// Bench for d_mem_arbiter: directed vector table, contention and abort
// sequences, then randomized traffic against a transaction-level model.
module tb_d_mem_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int RS = 256;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          ack0, ack1, err0, err1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_write, mem_read;

  always #5 clk = ~clk;

  d_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_SIZE(RS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .Req0         (req0),
    .Req1         (req1),
    .We0          (we0),
    .We1          (we1),
    .Addr0        (addr0),
    .Addr1        (addr1),
    .WData0       (wdata0),
    .WData1       (wdata1),
    .Ack0         (ack0),
    .Ack1         (ack1),
    .Err0         (err0),
    .Err1         (err1),
    .RData0       (rdata0),
    .RData1       (rdata1),
    .MemAddress   (mem_address),
    .MemWriteData (mem_wdata),
    .MemWrite     (mem_write),
    .MemRead      (mem_read),
    .MemReadData  (mem_rdata)
  );

  // d_mem stand-in: asynchronous read, synchronous write
  logic [DW-1:0] dmem [RS];
  always @(posedge clk) if (mem_write && mem_address < 32'(RS)) dmem[mem_address[7:0]] <= mem_wdata;
  assign mem_rdata = (mem_address < 32'(RS)) ? dmem[mem_address[7:0]] : '0;

  // Reference model state
  logic [DW-1:0] ref_mem [RS];
  logic [DW-1:0] ref_rdata [2];
  bit            ref_last;

  int n_checks = 0;
  int n_pass   = 0;
  int viol     = 0;
  int strobe_total = 0;

  always @(negedge clk) begin
    if (mem_read | mem_write) strobe_total++;
    if (mem_read && mem_write) viol++;
    if (ack0 && ack1) viol++;
    if ((mem_read | mem_write) && mem_address >= 32'(RS)) viol++;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic void model(input bit p, input bit we, input logic [AW-1:0] a,
                                input logic [DW-1:0] wd, output bit e, output logic [DW-1:0] rd);
    if (a >= 32'(RS)) begin
      e = 1'b1;
      ref_rdata[p] = '0;
    end else begin
      e = 1'b0;
      if (we) ref_mem[a[7:0]] = wd;
      else ref_rdata[p] = ref_mem[a[7:0]];
    end
    rd = ref_rdata[p];
    ref_last = p;
  endfunction

  task automatic set_req(input bit p, input bit v, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd);
    if (!p) begin req0 = v; we0 = we; addr0 = a; wdata0 = wd; end
    else    begin req1 = v; we1 = we; addr1 = a; wdata1 = wd; end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    ref_rdata[0] = '0; ref_rdata[1] = '0; ref_last = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Called at a negedge with the arbiter idle; returns after the bus settles.
  task automatic run_single(input bit p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                            output bit got_ack, output bit got_err, output logic [DW-1:0] got_rd,
                            output int lat, output int strobes);
    int s0;
    s0 = strobe_total;
    got_ack = 1'b0; got_err = 1'b0; got_rd = '0; lat = 0;
    set_req(p, 1'b1, we, a, wd);
    for (int c = 0; c < 10 && !got_ack; c++) begin
      @(negedge clk);
      lat++;
      if (p ? ack1 : ack0) begin
        got_ack = 1'b1;
        got_err = p ? err1 : err0;
        got_rd  = p ? rdata1 : rdata0;
      end
    end
    set_req(p, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    strobes = strobe_total - s0;
  endtask

  typedef struct {
    bit            port;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    bit            exp_err;
    logic [DW-1:0] exp_rd;
    int            exp_strobes;
  } vec_t;

  vec_t vecs[13];

  initial begin
    bit            ga, ge, me;
    logic [DW-1:0] gr, mr;
    int            lat, stb, s0, acks;
    int            ack_port[4];
    int            ack_cyc[4];
    int            n_ack;

    vecs[0]  = '{1'b0, 1'b1, 32'd5,         32'hDEADBEEF, 1'b0, 32'h0,        1};
    vecs[1]  = '{1'b0, 1'b0, 32'd5,         32'h0,        1'b0, 32'hDEADBEEF, 1};
    vecs[2]  = '{1'b1, 1'b1, 32'd0,         32'h11111111, 1'b0, 32'h0,        1};
    vecs[3]  = '{1'b1, 1'b1, 32'd256,       32'h77777777, 1'b1, 32'h0,        0};
    vecs[4]  = '{1'b1, 1'b0, 32'd0,         32'h0,        1'b0, 32'h11111111, 1};
    vecs[5]  = '{1'b0, 1'b1, 32'd300,       32'h12345678, 1'b1, 32'h0,        0};
    vecs[6]  = '{1'b0, 1'b0, 32'd5,         32'h0,        1'b0, 32'hDEADBEEF, 1};
    vecs[7]  = '{1'b1, 1'b1, 32'd255,       32'hA5A5A5A5, 1'b0, 32'h11111111, 1};
    vecs[8]  = '{1'b1, 1'b0, 32'd255,       32'h0,        1'b0, 32'hA5A5A5A5, 1};
    vecs[9]  = '{1'b0, 1'b0, 32'hFFFFFFFF,  32'h0,        1'b1, 32'h0,        0};
    vecs[10] = '{1'b1, 1'b0, 32'd256,       32'h0,        1'b1, 32'h0,        0};
    vecs[11] = '{1'b0, 1'b0, 32'h00000100,  32'h0,        1'b1, 32'h0,        0};
    vecs[12] = '{1'b1, 1'b0, 32'd0,         32'h0,        1'b0, 32'h11111111, 1};

    for (int i = 0; i < RS; i++) begin
      dmem[i]    = 32'(i) * 32'h01000193;
      ref_mem[i] = 32'(i) * 32'h01000193;
    end
    ref_rdata[0] = '0; ref_rdata[1] = '0; ref_last = 1'b1;

    // Reset state, before any clock edge and after a few cycles in reset
    #2 rst_n = 1'b0;
    #1;
    check("rst_flags", {ack0, ack1, err0, err1, mem_write, mem_read}, 6'b0);
    check("rst_rdata0", rdata0, 0);
    check("rst_rdata1", rdata1, 0);
    check("rst_maddr", mem_address, 0);
    check("rst_mwdata", mem_wdata, 0);
    repeat (3) @(negedge clk);
    check("rst_held_flags", {ack0, ack1, err0, err1, mem_write, mem_read}, 6'b0);
    rst_n = 1'b1;
    s0 = strobe_total;
    repeat (10) @(negedge clk);
    check("idle_no_strobe", strobe_total - s0, 0);

    // Directed vector table
    for (int i = 0; i < 13; i++) begin
      run_single(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, ga, ge, gr, lat, stb);
      model(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, me, mr);
      check($sformatf("vec%0d_ack", i), ga, 1);
      check($sformatf("vec%0d_latency", i), lat, 2);
      check($sformatf("vec%0d_err", i), ge, vecs[i].exp_err);
      check($sformatf("vec%0d_rdata", i), gr, vecs[i].exp_rd);
      check($sformatf("vec%0d_strobes", i), stb, vecs[i].exp_strobes);
    end
    check("oob_write_mem0", dmem[0], 32'h11111111);

    // Contention: both requests held through four grants
    do_reset();
    set_req(0, 1'b1, 1'b0, 32'd5, '0);
    set_req(1, 1'b1, 1'b0, 32'd255, '0);
    n_ack = 0;
    for (int c = 1; c <= 30 && n_ack < 4; c++) begin
      @(negedge clk);
      if (ack0 | ack1) begin
        ack_port[n_ack] = ack1 ? 1 : 0;
        ack_cyc[n_ack]  = c;
        model(ack1, 1'b0, ack1 ? 32'd255 : 32'd5, '0, me, mr);
        check($sformatf("cont%0d_rdata", n_ack), ack1 ? rdata1 : rdata0, mr);
        n_ack++;
        if (n_ack == 4) begin req0 = 1'b0; req1 = 1'b0; end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    check("cont_ack_count", n_ack, 4);
    if (n_ack == 4) begin
      check("cont_order0", ack_port[0], 0);
      check("cont_order1", ack_port[1], 1);
      check("cont_order2", ack_port[2], 0);
      check("cont_order3", ack_port[3], 1);
      check("cont_first_lat", ack_cyc[0], 2);
      for (int k = 1; k < 4; k++) check($sformatf("cont_gap%0d", k), ack_cyc[k] - ack_cyc[k-1], 3);
    end
    repeat (2) @(negedge clk);

    // Reset during ACCESS aborts the write
    set_req(0, 1'b1, 1'b1, 32'd7, 32'hCAFEF00D);
    @(negedge clk);
    check("abort_strobe_up", {mem_write, mem_read}, 2'b10);
    rst_n = 1'b0;
    #1;
    check("abort_strobe_drop", {mem_write, mem_read}, 2'b00);
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b1, 1'b0, 32'd5, '0);
    ref_rdata[0] = '0; ref_rdata[1] = '0; ref_last = 1'b1;
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      if (ack0 | ack1) acks++;
    end
    check("abort_no_ack", acks, 0);
    check("abort_mem_untouched", dmem[7], ref_mem[7]);
    rst_n = 1'b1;
    ga = 1'b0; lat = 0;
    for (int c = 0; c < 10 && !ga; c++) begin
      @(negedge clk);
      lat++;
      if (ack0) acks++;
      if (ack1) begin ga = 1'b1; ge = err1; gr = rdata1; end
    end
    set_req(1, 1'b0, 1'b0, '0, '0);
    model(1'b1, 1'b0, 32'd5, '0, me, mr);
    check("post_abort_ack1", ga, 1);
    check("post_abort_no_ack0", acks, 0);
    check("post_abort_lat", lat, 2);
    check("post_abort_rdata", gr, mr);
    @(negedge clk);

    // Randomized traffic against the transaction-level model
    for (int r = 0; r < 80; r++) begin
      int            mask, nexp, got, sel;
      bit            order[2];
      bit            rwe[2];
      logic [AW-1:0] raddr[2];
      logic [DW-1:0] rwd[2];
      bit            p;
      mask = $urandom_range(1, 3);
      for (int q = 0; q < 2; q++) begin
        rwe[q] = 1'($urandom_range(0, 1));
        sel = $urandom_range(0, 9);
        if (sel < 8)       raddr[q] = 32'($urandom_range(0, RS - 1));
        else if (sel == 8) raddr[q] = 32'(RS + $urandom_range(0, 1000));
        else               raddr[q] = $urandom | 32'h80000000;
        rwd[q] = $urandom;
      end
      if (mask == 3) begin
        order[0] = ~ref_last; order[1] = ref_last; nexp = 2;
      end else begin
        order[0] = (mask == 2); order[1] = 1'b0; nexp = 1;
      end
      if (mask[0]) set_req(0, 1'b1, rwe[0], raddr[0], rwd[0]);
      if (mask[1]) set_req(1, 1'b1, rwe[1], raddr[1], rwd[1]);
      got = 0;
      for (int c = 0; c < 20 && got < nexp; c++) begin
        @(negedge clk);
        if (ack0 | ack1) begin
          p = ack1;
          check("rand_port", p, order[got]);
          model(order[got], rwe[order[got]], raddr[order[got]], rwd[order[got]], me, mr);
          check("rand_err", p ? err1 : err0, me);
          check("rand_rdata", p ? rdata1 : rdata0, mr);
          set_req(p, 1'b0, 1'b0, '0, '0);
          got++;
        end
      end
      if (got < nexp) begin
        check("rand_ack_timeout", got, nexp);
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        repeat (4) @(negedge clk);
      end
      @(negedge clk);
    end

    for (int i = 0; i < RS; i++) begin
      if (dmem[i] !== ref_mem[i]) viol++;
    end
    check("protocol_and_mem_violations", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
